// File: rtl/window_pkg.sv
// Shared types and default geometry for the sliding-window sequencing controller.
// The widths below follow the default image size; instances derive their own from their parameters.
package window_pkg;

  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;
  localparam int DEF_K     = 3;

  localparam int COL_W = $clog2(DEF_IMG_W);
  localparam int ROW_W = $clog2(DEF_IMG_H);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo-(MAX+1) counter with synchronous clear.
// The wrap output is combinational so a chained counter can advance on the same edge.
module wrap_counter #(
  parameter int MAX   = 639,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  assign wrap = inc && (count == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/window_ctrl.sv
// Raster sequencing controller for a KxK sliding window: gates the shared shift
// enable, tracks pixel position and flags cycles holding a complete in-bounds window.
module window_ctrl
  import window_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int K     = DEF_K,
  localparam int COL_BITS = $clog2(IMG_W),
  localparam int ROW_BITS = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  output logic                shift_en,
  output logic [COL_BITS-1:0] col,
  output logic [ROW_BITS-1:0] row,
  output logic                out_valid,
  output logic                busy,
  output logic                done
);

  localparam logic [COL_BITS-1:0] K_COL = COL_BITS'(K - 1);
  localparam logic [ROW_BITS-1:0] K_ROW = ROW_BITS'(K - 1);

  state_t state;
  logic   accept;
  logic   start_frame;
  logic   col_wrap;
  logic   last_pixel;
  logic   in_window;

  assign accept      = (state == RUN) && in_valid;
  assign shift_en    = accept;
  assign start_frame = (state == IDLE) && start;
  assign in_window   = (col >= K_COL) && (row >= K_ROW);

  wrap_counter #(
    .MAX   (IMG_W - 1),
    .WIDTH (COL_BITS)
  ) u_col (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_frame),
    .inc   (accept),
    .count (col),
    .wrap  (col_wrap)
  );

  // Row wrap only fires on the column wrap of the bottom row, i.e. the final pixel.
  wrap_counter #(
    .MAX   (IMG_H - 1),
    .WIDTH (ROW_BITS)
  ) u_row (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_frame),
    .inc   (col_wrap),
    .count (row),
    .wrap  (last_pixel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      out_valid <= accept && in_window;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (last_pixel) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_window_ctrl.sv
// Randomized bench for window_ctrl: a pixel-index model predicts every output each cycle,
// with per-frame literal counts and a 3x3 instance for the single-window case.
module tb_window_ctrl;

  localparam int W  = 5;
  localparam int H  = 4;
  localparam int KW = 3;

  logic clk = 1'b0;
  logic rst;
  logic start, in_valid, shift_en, out_valid, busy, done;
  logic [2:0] col;
  logic [1:0] row;

  logic start2, in_valid2, shift_en2, out_valid2, busy2, done2;
  logic [1:0] col2;
  logic [1:0] row2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  window_ctrl #(.IMG_W(W), .IMG_H(H), .K(KW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .shift_en  (shift_en),
    .col       (col),
    .row       (row),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  window_ctrl #(.IMG_W(3), .IMG_H(3), .K(3)) dut_small (
    .clk       (clk),
    .rst       (rst),
    .start     (start2),
    .in_valid  (in_valid2),
    .shift_en  (shift_en2),
    .col       (col2),
    .row       (row2),
    .out_valid (out_valid2),
    .busy      (busy2),
    .done      (done2)
  );

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is a count of accepted pixels; position is plain div/mod of that count.
  bit m_run  = 0;
  bit m_done = 0;
  bit m_ov   = 0;
  int m_idx  = 0;

  always @(posedge clk or negedge rst) begin
    bit acc;
    if (!rst) begin
      m_run = 0; m_done = 0; m_ov = 0; m_idx = 0;
    end else begin
      acc  = m_run && in_valid;
      m_ov = acc && (m_idx % W >= KW - 1) && (m_idx / W >= KW - 1);
      if (m_done) begin
        m_done = 0;
      end else if (m_run) begin
        if (acc) begin
          if (m_idx == W * H - 1) begin
            m_run = 0; m_done = 1; m_idx = 0;
          end else begin
            m_idx++;
          end
        end
      end else if (start) begin
        m_run = 1; m_idx = 0;
      end
    end
  end

  int acc_cnt, ov_cnt, done_cnt;
  int last_col, last_row, first_ov_col, first_ov_row;
  bit ov_seen;

  always @(negedge clk) begin
    check_output("shift_en", shift_en, int'(m_run && in_valid));
    check_output("col", col, m_idx % W);
    check_output("row", row, m_idx / W);
    check_output("out_valid", out_valid, m_ov);
    check_output("done", done, m_done);
    check_output("busy", busy, int'(m_run || m_done));
    if (out_valid && !ov_seen) begin
      ov_seen = 1; first_ov_col = last_col; first_ov_row = last_row;
    end
    if (shift_en) begin
      acc_cnt++; last_col = col; last_row = row;
    end
    if (out_valid) ov_cnt++;
    if (done) done_cnt++;
  end

  int acc2, ov2, done2_cnt, ov_done2, first_col2, first_row2;

  always @(negedge clk) begin
    if (shift_en2 && acc2 == 0) begin
      first_col2 = col2; first_row2 = row2;
    end
    if (shift_en2) acc2++;
    if (out_valid2) ov2++;
    if (done2) done2_cnt++;
    if (out_valid2 && done2) ov_done2++;
  end

  // mode 0: continuous, 1: toggling 1,0,1,0, 2: random stalls.
  task automatic apply_stimulus(input int mode, input bit spurious, input bit abort);
    int cyc = 0;
    start = 1'b1;
    in_valid = 1'($urandom_range(0, 1));
    acc_cnt = 0; ov_cnt = 0; done_cnt = 0; ov_seen = 0;
    first_ov_col = -1; first_ov_row = -1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_cnt == 0 && cyc < 300) begin
      if (abort && acc_cnt == 11) begin
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check_output("abort_shift_en", shift_en, 0);
        check_output("abort_busy", busy, 0);
        check_output("abort_out_valid", out_valid, 0);
        check_output("abort_done", done, 0);
        check_output("abort_col", col, 0);
        check_output("abort_row", row, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("abort_no_done", done_cnt, 0);
        check_output("abort_accepts", acc_cnt, 11);
        return;
      end
      cyc++;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = cyc[0];
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      start = 1'b0;
      if (spurious && acc_cnt == 6) begin
        in_valid = 1'b1; start = 1'b1;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check_output("frame_accepts", acc_cnt, 20);
    check_output("frame_out_valid", ov_cnt, 6);
    check_output("frame_done", done_cnt, 1);
    check_output("first_ov_col", first_ov_col, 2);
    check_output("first_ov_row", first_ov_row, 2);
  endtask

  task automatic small_frame();
    int cyc = 0;
    start2 = 1'b1; in_valid2 = 1'b1;
    acc2 = 0; ov2 = 0; done2_cnt = 0; ov_done2 = 0;
    first_col2 = -1; first_row2 = -1;
    @(posedge clk); #1;
    start2 = 1'b0;
    while (done2_cnt == 0 && cyc < 100) begin
      cyc++;
      in_valid2 = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
    end
    check_output("small_accepts", acc2, 9);
    check_output("small_out_valid", ov2, 1);
    check_output("small_done", done2_cnt, 1);
    check_output("small_ov_with_done", ov_done2, 1);
    check_output("small_first_col", first_col2, 0);
    check_output("small_first_row", first_row2, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b1;
    start2 = 1'b0; in_valid2 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_output("reset_shift_en", shift_en, 0);
      check_output("reset_out_valid", out_valid, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_col", col, 0);
      check_output("reset_row", row, 0);
    end
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("idle_shift_en", shift_en, 0);
      check_output("idle_busy", busy, 0);
      check_output("idle_col", col, 0);
    end
    @(posedge clk); #1;

    apply_stimulus(0, 0, 0);
    @(negedge clk);
    check_output("idle_after_frame_busy", busy, 0);
    @(posedge clk); #1;
    apply_stimulus(1, 0, 0);
    repeat (2) @(posedge clk); #1;
    apply_stimulus(2, 1, 0);
    repeat (2) @(posedge clk); #1;
    apply_stimulus(0, 0, 1);
    apply_stimulus(2, 0, 0);
    apply_stimulus(0, 0, 0);
    apply_stimulus(2, 0, 0);

    small_frame();
    small_frame();
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/window_ctrl.md
# window_ctrl

Sequencing controller for the K×K sliding-window datapath built from enabled register stages (`dff` chains plus line buffers) in the image filter pipeline. It accepts a raster pixel stream and drives the shared shift enable so every stage advances only on accepted pixels. It tracks column and row position and flags the cycles on which the register window holds a complete, in-bounds K×K neighbourhood. It sits between the pixel source and the filter kernels (median, Gaussian, Sobel).

## Interface
- IMG_W, 640, pixels per row (≥ K)
- IMG_H, 480, rows per frame (≥ K)
- K, 3, window size (odd, ≥ 3)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  single-cycle pulse that arms a new frame
- in_valid  input  1  pixel present on datapath input this cycle
- shift_en  output  1  enable for all window `dff`/line-buffer stages
- col  output  $clog2(IMG_W)  column of the pixel being accepted
- row  output  $clog2(IMG_H)  row of the pixel being accepted
- out_valid  output  1  window registers hold a complete K×K neighbourhood
- busy  output  1  frame in progress
- done  output  1  single-cycle pulse after the last pixel of the frame

## Operation
- States:
  - IDLE: waits for `start`.
  - RUN: accepts pixels.
  - DONE: lasts one cycle, then returns to IDLE.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when a pixel is accepted at col=IMG_W-1, row=IMG_H-1.
  - DONE→IDLE unconditionally.
- Accept condition: state==RUN && in_valid. `shift_en` equals the accept condition.
- Counters:
  - `col` increments on each accept and wraps IMG_W-1→0.
  - On the wrap, `row` increments; `row` wraps IMG_H-1→0 at frame end.
  - Both counters clear to 0 on entry to RUN.
- Window validity: an accept with col ≥ K-1 and row ≥ K-1 sets `out_valid` on the next cycle. No border padding: each frame yields exactly (IMG_W-K+1)·(IMG_H-K+1) `out_valid` cycles.
- `busy` is 1 in RUN and DONE.
- Illegal or simultaneous events:
  - `in_valid` in IDLE or DONE is ignored: `shift_en` stays 0 and counters hold.
  - `start` in RUN or DONE is ignored.
  - `start` coinciding with DONE is dropped. The source must re-issue it in IDLE.
- Stall: `in_valid` low in RUN holds all counters and deasserts `shift_en`. `out_valid` deasserts the cycle after a stall cycle.

## Timing
- Reset values (asynchronous on rst=0): state=IDLE, col=0, row=0, out_valid=0, done=0, busy=0, shift_en=0.
- Reset mid-frame aborts immediately. No `done` is produced, and the next frame requires a new `start`.
- `shift_en` is combinational (0-cycle latency), so the window stages capture on the same edge the pixel is accepted.
- `out_valid`, `done` and `busy` are registered.
  - `out_valid` has 1-cycle latency, aligned with the updated `dff` Q outputs.
  - `done` is high for exactly the cycle after the final accept.
- `col`/`row` reflect the position of the pixel on the input during the accept cycle. They update on the edge that consumes it.
- Throughput: one pixel per clock. A back-to-back frame (`start` in the cycle after DONE) needs 1 idle cycle.

## Structure
- Shared package `window_pkg`:
  - state enum (IDLE, RUN, DONE);
  - localparams COL_W = $clog2(IMG_W) and ROW_W = $clog2(IMG_H);
  - default K.
- Sub-module `wrap_counter` (params MAX, WIDTH; ports clk, rst, clr, inc, count, wrap): instantiated twice for `col` and `row`. The column wrap drives the row `inc`.
- Top level: FSM, accept logic, window-valid register, done pulse.

## Test plan
All scenarios use IMG_W=5, IMG_H=4, K=3 unless stated.
- Reset then idle: rst=0 for 3 cycles, in_valid=1 with no start → shift_en=0, out_valid=0, busy=0, col=row=0 throughout.
- Continuous frame: start, then 20 cycles in_valid=1 →
  - 20 `shift_en` pulses;
  - first `out_valid` the cycle after accept (col=2,row=2);
  - 6 `out_valid` cycles total;
  - `done` 1 cycle after the 20th accept;
  - then IDLE with busy=0.
- Stalls: same frame with in_valid toggled 1,0,1,0… → still 20 accepts, 6 `out_valid`; col/row hold on every in_valid=0 cycle.
- Spurious start: a second start pulse at accept #7 → ignored; frame completes at accept #20 with a single `done`.
- Reset mid-frame: drop rst at accept #11 → all outputs 0 asynchronously, no `done`. A fresh start then yields a normal 20-pixel frame.
- Back-to-back frames: start asserted in the cycle after `done` → second frame yields 6 `out_valid` cycles and counters restart at 0,0. Repeat with IMG_W=3, IMG_H=3 → exactly 1 `out_valid` per frame.
